licznik_rozkazow: RTL and testbench
===================================

LICZNIK_ROZKAZOW -- requirements
Module: licznik_rozkazow

Interface
REQ-001 Parameter PC_WIDTH, default 8, program counter and jump-address width.
REQ-002 Parameter STOS_GLEB, default 8, return-address stack depth in entries; legal range 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ce  input  1  advance enable; low = freeze PC and stack.
REQ-006 rst_sw  input  1  soft reset from decoder (RST instruction).
REQ-007 skok  input  1  jump request.
REQ-008 adres_skok  input  PC_WIDTH  jump target.
REQ-009 skok_pc  input  1  with skok: target comes from stack top (RET/RETI).
REQ-010 push_pc  input  1  push return address (CALL/interrupt entry).
REQ-011 pop_pc  input  1  pop stack top.
REQ-012 przerwanie  input  1  push_pc is interrupt entry; return address = current PC.
REQ-013 pc  output  PC_WIDTH  current instruction address to program ROM.
REQ-014 stos_pc_empty  output  1  stack holds 0 entries.
REQ-015 stos_pc_full  output  1  stack holds STOS_GLEB entries.
REQ-016 blad_stosu  output  1  sticky stack-fault flag (see Configuration).

Function
REQ-017 pc, empty, full are registered; pc change takes effect the cycle after the request (1-cycle latency).
REQ-018 Next-PC priority: rst > rst_sw > !ce (hold) > skok&skok_pc > skok > pc+1.
REQ-019 skok&skok_pc&pop_pc with stack non-empty: pc <= top entry, pointer decremented, same edge.
REQ-020 skok&!skok_pc: pc <= adres_skok.
REQ-021 No request: pc <= pc+1 modulo 2^PC_WIDTH (0xFF wraps to 0x00).
REQ-022 push_pc with stack not full: writes pc+1 (przerwanie=0) or pc (przerwanie=1), modulo 2^PC_WIDTH, pointer incremented.
REQ-023 push_pc on full: push ignored, stack unchanged; PC update per REQ-018 still occurs.
REQ-024 pop_pc on empty: pop ignored; if skok_pc also set, pc <= pc+1 instead of stack value.
REQ-025 push_pc and pop_pc same cycle: pop wins, push ignored.
REQ-026 Stack pointer is a counter 0..STOS_GLEB; empty = (ptr==0), full = (ptr==STOS_GLEB), both recomputed from registered pointer.
REQ-027 While ce=0 all inputs except rst/rst_sw are ignored.

Reset
REQ-028 rst or rst_sw (any ce): pc=0x00, pointer=0, empty=1, full=0, blad_stosu=0.
REQ-029 Reset during a pending push/pop/jump discards the request; stack contents need not be cleared, only pointer.

Configuration
REQ-030 Macro STOS_PC_BLAD_EN defined: blad_stosu set on push_pc while full or pop_pc while empty, held until reset.
REQ-031 Macro undefined: blad_stosu tied 0, no fault logic synthesised; REQ-023/024 behaviour unchanged.

Structure
REQ-032 Shared package holds PC_WIDTH default, reset vector 0x00, exception vector 0x06.
REQ-033 LIFO storage and pointer in sub-module stos_pc (push, pop, din, top, empty, full); PC register and next-PC mux in top.

Verification
REQ-034 rst 1 cycle, then 4 idle ce=1 cycles -> pc 0,1,2,3,4; empty=1.
REQ-035 pc=0x10, skok=1, push_pc=1, adres_skok=0x40 -> pc=0x40 next cycle; later skok,skok_pc,pop_pc -> pc=0x11, empty=1.
REQ-036 pc=0x25, przerwanie=1, push_pc=1, skok=1, adres_skok=0x08 -> pc=0x08; RETI pop -> pc=0x25.
REQ-037 STOS_GLEB pushes -> full=1; extra push -> pointer unchanged, blad_stosu=1 (macro on) / 0 (off); pop order LIFO verified.
REQ-038 pc=0xFF idle -> pc=0x00; pop on empty with skok_pc -> pc increments, blad_stosu=1 (macro on).
REQ-039 Three pushes then rst_sw with skok asserted -> pc=0x00, empty=1, full=0, blad_stosu=0.

Source files
------------

// File: rtl/licznik_rozkazow_pkg.sv
// Shared definitions for the program counter block: default width, fixed vectors
// and the next-PC source selector.
package licznik_rozkazow_pkg;

    localparam int         PC_WIDTH_DEF = 8;
    localparam logic [7:0] RESET_VEC    = 8'h00;
    localparam logic [7:0] EXC_VEC      = 8'h06;

    typedef enum logic [2:0] {
        SEL_RESET,
        SEL_HOLD,
        SEL_STACK,
        SEL_JUMP,
        SEL_INC
    } pc_sel_t;

endpackage

// File: rtl/licznik_rozkazow_stos_pc.sv
// Return-address LIFO for the program counter; the pointer counts 0..DEPTH entries.
// Optional sticky fault flag is built only when STOS_PC_BLAD_EN is defined.
module stos_pc #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             blad
);

    localparam int PW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [PW-1:0]    ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    rd_idx;
    logic             do_push;
    logic             do_pop;

    assign empty   = (ptr == '0);
    assign full    = (ptr == PW'(DEPTH));
    // A simultaneous pop takes precedence, so the push is dropped entirely.
    assign do_pop  = pop && !empty;
    assign do_push = push && !pop && !full;
    assign wr_idx  = IW'(ptr);
    assign rd_idx  = IW'(ptr - PW'(1));
    assign top     = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (do_pop) begin
            ptr <= ptr - PW'(1);
        end else if (do_push) begin
            ptr <= ptr + PW'(1);
        end
    end

    // Storage is never cleared; only the pointer decides which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_idx] <= din;
        end
    end

`ifdef STOS_PC_BLAD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            blad <= 1'b0;
        end else if ((push && !pop && full) || (pop && empty)) begin
            blad <= 1'b1;
        end
    end
`else
    assign blad = 1'b0;
`endif

endmodule

// File: rtl/licznik_rozkazow.sv
// Program counter with return-address stack for CALL/RET/interrupt entry.
// Define STOS_PC_BLAD_EN to enable the sticky stack-fault flag blad_stosu.
module licznik_rozkazow
    import licznik_rozkazow_pkg::*;
#(
    parameter int PC_WIDTH  = PC_WIDTH_DEF,
    parameter int STOS_GLEB = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic                rst_sw,
    input  logic                skok,
    input  logic [PC_WIDTH-1:0] adres_skok,
    input  logic                skok_pc,
    input  logic                push_pc,
    input  logic                pop_pc,
    input  logic                przerwanie,
    output logic [PC_WIDTH-1:0] pc,
    output logic                stos_pc_empty,
    output logic                stos_pc_full,
    output logic                blad_stosu
);

    pc_sel_t             sel;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] pc_next;
    logic [PC_WIDTH-1:0] stack_top;
    logic [PC_WIDTH-1:0] stack_din;
    logic                stack_rst;

    assign pc_inc    = pc + PC_WIDTH'(1);
    assign stack_din = przerwanie ? pc : pc_inc;
    assign stack_rst = rst || rst_sw;

    // A return with an empty stack falls through to the next instruction.
    always_comb begin
        sel = SEL_INC;
        if (rst_sw) begin
            sel = SEL_RESET;
        end else if (!ce) begin
            sel = SEL_HOLD;
        end else if (skok && skok_pc) begin
            sel = stos_pc_empty ? SEL_INC : SEL_STACK;
        end else if (skok) begin
            sel = SEL_JUMP;
        end
    end

    always_comb begin
        pc_next = pc_inc;
        case (sel)
            SEL_RESET: pc_next = PC_WIDTH'(RESET_VEC);
            SEL_HOLD:  pc_next = pc;
            SEL_STACK: pc_next = stack_top;
            SEL_JUMP:  pc_next = adres_skok;
            default:   pc_next = pc_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= PC_WIDTH'(RESET_VEC);
        end else begin
            pc <= pc_next;
        end
    end

    stos_pc #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STOS_GLEB)
    ) u_stos (
        .clk   (clk),
        .rst   (stack_rst),
        .push  (ce && push_pc),
        .pop   (ce && pop_pc),
        .din   (stack_din),
        .top   (stack_top),
        .empty (stos_pc_empty),
        .full  (stos_pc_full),
        .blad  (blad_stosu)
    );

endmodule

// File: tb/tb_licznik_rozkazow.sv
// Table-driven self-checking bench for licznik_rozkazow with an expected-value queue.
// Fault-flag expectations follow STOS_PC_BLAD_EN.
module tb_licznik_rozkazow;

`ifdef STOS_PC_BLAD_EN
    localparam bit BLAD_EN = 1'b1;
`else
    localparam bit BLAD_EN = 1'b0;
`endif
    localparam int DEPTH = 8;

    typedef struct {
        logic       rst, rst_sw, ce, skok, skok_pc, push_pc, pop_pc, przerwanie;
        logic [7:0] adres;
        logic [7:0] e_pc;
        logic       e_empty, e_full, e_blad;
    } vec_t;

    typedef struct {
        logic [7:0] pc;
        logic       empty, full, blad;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, ce, rst_sw, skok, skok_pc, push_pc, pop_pc, przerwanie;
    logic [7:0] adres_skok;
    logic [7:0] pc;
    logic       stos_pc_empty, stos_pc_full, blad_stosu;

    exp_t sb[$];
    vec_t tbl[17];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    licznik_rozkazow #(.PC_WIDTH(8), .STOS_GLEB(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .ce            (ce),
        .rst_sw        (rst_sw),
        .skok          (skok),
        .adres_skok    (adres_skok),
        .skok_pc       (skok_pc),
        .push_pc       (push_pc),
        .pop_pc        (pop_pc),
        .przerwanie    (przerwanie),
        .pc            (pc),
        .stos_pc_empty (stos_pc_empty),
        .stos_pc_full  (stos_pc_full),
        .blad_stosu    (blad_stosu)
    );

    function automatic vec_t mk(input logic r, rs, c, s, sp, pu, po, pz,
                                input logic [7:0] a, input logic [7:0] epc,
                                input logic ee, ef, eb);
        vec_t v;
        v.rst = r; v.rst_sw = rs; v.ce = c; v.skok = s; v.skok_pc = sp;
        v.push_pc = pu; v.pop_pc = po; v.przerwanie = pz; v.adres = a;
        v.e_pc = epc; v.e_empty = ee; v.e_full = ef; v.e_blad = eb;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        rst = v.rst; rst_sw = v.rst_sw; ce = v.ce; skok = v.skok; skok_pc = v.skok_pc;
        push_pc = v.push_pc; pop_pc = v.pop_pc; przerwanie = v.przerwanie; adres_skok = v.adres;
        e.pc = v.e_pc; e.empty = v.e_empty; e.full = v.e_full; e.blad = v.e_blad & BLAD_EN;
        sb.push_back(e);
    endtask

    task automatic cmp1(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL %s: scoreboard empty, got pc %h, expected an entry", tag, pc);
        end else begin
            e = sb.pop_front();
            cmp1({tag, ".pc"},    pc,                    e.pc);
            cmp1({tag, ".empty"}, {7'd0, stos_pc_empty}, {7'd0, e.empty});
            cmp1({tag, ".full"},  {7'd0, stos_pc_full},  {7'd0, e.full});
            cmp1({tag, ".blad"},  {7'd0, blad_stosu},    {7'd0, e.blad});
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        applyStimulus(v);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        rst = 1'b1; rst_sw = 1'b0; ce = 1'b0; skok = 1'b0; skok_pc = 1'b0;
        push_pc = 1'b0; pop_pc = 1'b0; przerwanie = 1'b0; adres_skok = 8'h00;

        //             r  rs c  s  sp pu po pz adres   pc     e  f  b
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0);
        tbl[1]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h01, 1, 0, 0);
        tbl[2]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h02, 1, 0, 0);
        tbl[3]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h03, 1, 0, 0);
        tbl[4]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h04, 1, 0, 0);
        tbl[5]  = mk(0, 0, 0, 1, 1, 1, 1, 0, 8'h55, 8'h04, 1, 0, 0);
        tbl[6]  = mk(0, 0, 1, 1, 0, 0, 0, 0, 8'h10, 8'h10, 1, 0, 0);
        tbl[7]  = mk(0, 0, 1, 1, 0, 1, 0, 0, 8'h40, 8'h40, 0, 0, 0);
        tbl[8]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h41, 0, 0, 0);
        tbl[9]  = mk(0, 0, 1, 1, 1, 0, 1, 0, 8'h00, 8'h11, 1, 0, 0);
        tbl[10] = mk(0, 0, 1, 1, 0, 0, 0, 0, 8'h25, 8'h25, 1, 0, 0);
        tbl[11] = mk(0, 0, 1, 1, 0, 1, 0, 1, 8'h08, 8'h08, 0, 0, 0);
        tbl[12] = mk(0, 0, 1, 1, 1, 0, 1, 0, 8'h00, 8'h25, 1, 0, 0);
        tbl[13] = mk(0, 0, 1, 1, 0, 0, 0, 0, 8'hFF, 8'hFF, 1, 0, 0);
        tbl[14] = mk(0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0);
        tbl[15] = mk(0, 0, 1, 1, 1, 0, 1, 0, 8'h00, 8'h01, 1, 0, 1);
        tbl[16] = mk(1, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < 17; i++) begin
            step(tbl[i], $sformatf("tbl%0d", i));
        end

        // Fill the stack, overflow it once, then unwind in LIFO order.
        for (int i = 0; i < DEPTH; i++) begin
            step(mk(0, 0, 1, 0, 0, 1, 0, 0, 8'h00, 8'(i + 1), 0, (i == DEPTH - 1), 0),
                 $sformatf("fill%0d", i));
        end
        step(mk(0, 0, 1, 1, 0, 1, 0, 0, 8'h30, 8'h30, 0, 1, 1), "overflow");
        for (int i = 0; i < DEPTH; i++) begin
            step(mk(0, 0, 1, 1, 1, 0, 1, 0, 8'h00, 8'(DEPTH - i), (i == DEPTH - 1), 0, 1),
                 $sformatf("unwind%0d", i));
        end
        step(mk(1, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0), "rst2");

        // Soft reset wins over pending jump/push and clears the fault flag.
        step(mk(0, 0, 1, 0, 0, 0, 1, 0, 8'h00, 8'h01, 1, 0, 1), "pop_empty");
        step(mk(0, 0, 1, 0, 0, 1, 0, 0, 8'h00, 8'h02, 0, 0, 1), "push_a");
        step(mk(0, 0, 1, 0, 0, 1, 0, 0, 8'h00, 8'h03, 0, 0, 1), "push_b");
        step(mk(0, 0, 1, 0, 0, 1, 0, 0, 8'h00, 8'h04, 0, 0, 1), "push_c");
        step(mk(0, 1, 1, 1, 0, 1, 0, 0, 8'h77, 8'h00, 1, 0, 0), "rst_sw");

        // Push and pop together: the pop returns the old top, the push is lost.
        step(mk(0, 0, 1, 0, 0, 1, 0, 0, 8'h00, 8'h01, 0, 0, 0), "push_d");
        step(mk(0, 0, 1, 1, 1, 1, 1, 0, 8'h00, 8'h01, 1, 0, 0), "push_pop");
        step(mk(0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h02, 1, 0, 0), "after_pp");

        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL leftover: got %0d queued entries, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
